// File: rtl/hilo_div_pkg.sv
// Shared CPU definitions: ALU control codes plus the HI/LO divider state
// encoding and iteration count.
package hilo_div_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluCtrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_e;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, record the quotient bit.
module div_step (
    input  logic [32:0] remIn,
    input  logic [31:0] quoIn,
    input  logic [31:0] divisor,
    output logic [32:0] remOut,
    output logic [31:0] quoOut
);

    logic [33:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {remIn, quoIn[31]};
        diff    = shifted - {2'b00, divisor};
        // partial remainder stays below the divisor, so bit 33 is a clean borrow
        if (diff[33]) begin
            remOut = shifted[32:0];
            quoOut = {quoIn[30:0], 1'b0};
        end else begin
            remOut = diff[32:0];
            quoOut = {quoIn[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle HI/LO divider for div/divu: iterates on magnitudes, then applies
// the quotient/remainder sign fix-up when writing HI/LO on entry to DONE.
module hilo_div #(
    parameter int DIV_CYCLES = hilo_div_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    output logic        busy,
    output logic        ready,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import hilo_div_pkg::*;

    divState_e   state, nxtState;
    logic [CNT_W-1:0] cnt;
    logic [32:0] remR, remNext;
    logic [31:0] quoR, quoNext, divR;
    logic        negQ, negR, bZero;
    logic        accept, lastStep;
    logic [31:0] absA, absB;

    assign accept   = (state == IDLE) && start && !annul;
    assign lastStep = (state == CALC) && (cnt == CNT_W'(DIV_CYCLES - 1));
    assign busy     = accept || (state == CALC);
    // an annul landing in DONE suppresses the write enable
    assign ready    = (state == DONE) && !annul;

    assign absA = (signed_div && a[31]) ? -a : a;
    assign absB = (signed_div && b[31]) ? -b : b;

    div_step uStep (
        .remIn   (remR),
        .quoIn   (quoR),
        .divisor (divR),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxtState;
    end

    always_comb begin
        nxtState = state;
        case (state)
            IDLE: if (accept) nxtState = CALC;
            CALC: begin
                if (annul)         nxtState = IDLE;
                else if (lastStep) nxtState = DONE;
            end
            DONE:    nxtState = IDLE;
            default: nxtState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            remR  <= '0;
            quoR  <= '0;
            divR  <= '0;
            negQ  <= 1'b0;
            negR  <= 1'b0;
            bZero <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            cnt   <= '0;
            remR  <= '0;
            quoR  <= absA;
            divR  <= absB;
            negQ  <= signed_div && (a[31] ^ b[31]);
            negR  <= signed_div && a[31];
            bZero <= (b == 32'd0);
        end else if ((state == CALC) && !annul) begin
            remR <= remNext;
            quoR <= quoNext;
            cnt  <= cnt + 1'b1;
            if (lastStep) begin
                // divide-by-zero yields all-ones quotient regardless of signs
                lo <= bZero ? 32'hFFFF_FFFF : (negQ ? -quoNext : quoNext);
                hi <= negR ? -remNext[31:0] : remNext[31:0];
            end
        end
    end

endmodule

// File: tb/tb_hilo_div.sv
// Directed bench for hilo_div: fixed-latency divides, sign and zero corners,
// annul cancel, ignored start, and asynchronous reset mid-operation.
module tb_hilo_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        annul = 1'b0;
    logic        busy, ready;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    hilo_div #(.DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is positioned just after a rising edge; start is cycle 1.
    // glitch > 0 re-asserts start with other operands in that cycle.
    task automatic doDiv(input string tag, input logic sgn, input logic [31:0] da,
                         input logic [31:0] db, input logic [31:0] expLo,
                         input logic [31:0] expHi, input int glitch);
        start = 1'b1; signed_div = sgn; a = da; b = db;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c < 34) begin
                check({tag, " busy"}, {31'd0, busy}, 32'd1);
                check({tag, " ready"}, {31'd0, ready}, 32'd0);
            end else begin
                check({tag, " busy@34"}, {31'd0, busy}, 32'd0);
                check({tag, " ready@34"}, {31'd0, ready}, 32'd1);
                check({tag, " lo"}, lo, expLo);
                check({tag, " hi"}, hi, expHi);
            end
            @(posedge clk); #1;
            if (c + 1 == glitch) begin
                start = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        bit sawReady;

        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // accepted at the first edge after reset; start during CALC ignored
        doDiv("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 5);
        doDiv("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        doDiv("divu by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
        doDiv("div by0", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 0);
        doDiv("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);

        // annul in cycle 10 of 100/7, new start in cycle 15
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 10) begin
                check("cancel busy", {31'd0, busy}, 32'd1);
            end else begin
                check("cancel idle busy", {31'd0, busy}, 32'd0);
                check("cancel lo held", lo, 32'h8000_0000);
                check("cancel hi held", hi, 32'd0);
            end
            check("cancel ready", {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
            annul = (c == 9);
        end
        doDiv("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        // annul beats start in IDLE
        start = 1'b1; annul = 1'b1; a = 32'd20; b = 32'd4;
        @(negedge clk);
        check("annul+start busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        check("annul+start not accepted", {31'd0, busy}, 32'd0);
        check("annul+start lo held", lo, 32'd3);
        @(posedge clk); #1;

        // asynchronous reset mid-CALC
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst ready", {31'd0, ready}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        @(negedge clk); rst = 1'b0;
        sawReady = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) sawReady = 1'b1;
        end
        check("rst no ready", {31'd0, sawReady}, 32'd0);
        check("rst lo stays", lo, 32'd0);
        @(posedge clk); #1;
        doDiv("divu after rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_div.md
HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 Parameter DIV_CYCLES, default 32: number of iteration cycles; fixed at 32 for this core.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  single-cycle request from the EX stage on decoded div/divu.
REQ-006 signed_div  in  1  1 = div (two's complement), 0 = divu; sampled with start.
REQ-007 a  in  32  dividend (rs); sampled with start.
REQ-008 b  in  32  divisor (rt); sampled with start.
REQ-009 annul  in  1  pipeline flush; cancels any operation in progress.
REQ-010 busy  out  1  stall request to the hazard logic.
REQ-011 ready  out  1  one-cycle completion pulse; the HI/LO write enable.
REQ-012 hi  out  32  remainder.
REQ-013 lo  out  32  quotient.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 In IDLE, start=1 with annul=0 SHALL latch a, b and signed_div, clear the iteration counter, and enter CALC at the next edge.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle, then enter DONE after exactly DIV_CYCLES steps.
REQ-017 DONE SHALL last one cycle: ready=1, hi/lo updated, then return to IDLE.
- Latency: ready high in the 34th cycle, counting the start cycle as cycle 1.
REQ-018 busy SHALL be combinational: (IDLE and start and not annul) or CALC. It is 0 in DONE, so the stalled instruction advances with ready.
REQ-019 start in CALC or DONE SHALL be ignored.
REQ-020 Signed mode rules:
- iterate on absolute values;
- quotient negated when a[31] xor b[31];
- remainder takes the sign of a.
REQ-021 Divide by zero (b=0) SHALL raise no exception, take the normal latency, and return lo=32'hFFFFFFFF, hi=a. This applies in both modes.
REQ-022 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF) SHALL return lo=32'h80000000, hi=0.
REQ-023 annul=1 in CALC or DONE SHALL force IDLE at the next edge:
- no ready pulse;
- hi/lo unchanged.
REQ-024 start and annul both high in IDLE: annul wins, and the request is not accepted.
REQ-025 hi/lo SHALL be registered and change only on entry to DONE; they hold between operations.
REQ-026 Intermediate arithmetic SHALL use a 33-bit partial remainder; no internal width truncation before the final sign fix-up.

Reset
REQ-027 rst=1 SHALL asynchronously force all of the following, including mid-CALC, with no completion pulse:
- state IDLE, counter 0;
- busy=0, ready=0;
- hi=0, lo=0;
- latched operands 0.
REQ-028 After rst deasserts, start SHALL be accepted at the first rising edge.

Structure
REQ-029 The state encoding (IDLE/CALC/DONE) and DIV_CYCLES SHALL live in the shared CPU package alongside the ALU control codes.
REQ-030 One combinational sub-module, div_step, SHALL implement a single shift-subtract step. Its interface:
- inputs: partial remainder, quotient bits, divisor;
- outputs: next partial remainder and quotient.
REQ-031 hilo_div SHALL own the FSM, counter, operand registers, and sign handling.

Verification
REQ-032 Unsigned: divu, a=100, b=7 -> ready in cycle 34; lo=14, hi=2; busy high in cycles 1-33.
REQ-033 Signed: div, a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
REQ-034 Corners:
- b=0, a=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678 at normal latency;
- signed 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-035 Cancel: annul at cycle 10 of 100/7 -> IDLE at cycle 11, no ready pulse, hi/lo keep prior values. A start at cycle 15 is accepted; 9/3 gives lo=3, hi=0.
REQ-036 Reset and ignored start:
- rst pulse mid-CALC -> all outputs 0 immediately, no ready pulse;
- start asserted during CALC -> ignored, operands of the first operation unchanged.
